// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
//  tx_state_t    : serialiser FSM states
//  PAR_*         : encodings of the PARITY configuration field
//  MIN_DATA_BITS : smallest frame data width accepted
//  clampBits()   : folds a requested data width into MIN_DATA_BITS..maxBits
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int MIN_DATA_BITS = 5;

  function automatic logic [3:0] clampBits(input logic [3:0] req, input int maxBits);
    if (req < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    if (req > 4'(maxBits))       return 4'(maxBits);
    return req;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// Write-side bus between the register front end and the UART Tx FIFO.
//  master : front end (drives WR_EN/WR_DATA/FIFO_FLUSH, reads the FIFO status)
//  slave  : uart_tx_fifo_ctrl (reads the push/flush strobes, drives the status)
interface uart_tx_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int LVL_W  = 5
);
  logic              WR_EN;
  logic [DATA_W-1:0] WR_DATA;
  logic              FIFO_FLUSH;
  logic              FULL;
  logic              EMPTY;
  logic [LVL_W-1:0]  LEVEL;
  logic              OVERFLOW;

  modport master (output WR_EN, WR_DATA, FIFO_FLUSH,
                  input  FULL, EMPTY, LEVEL, OVERFLOW);
  modport slave  (input  WR_EN, WR_DATA, FIFO_FLUSH,
                  output FULL, EMPTY, LEVEL, OVERFLOW);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO for the UART transmit path.
//  wrEn/wrData : push (dropped when full, which pulses overflow next cycle)
//  pop         : read strobe; rdData shows the head entry combinationally
//  flush       : clears pointers next cycle; a same-cycle push is discarded silently
//  full/empty/level/overflow : registered status
module uart_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              wrEn,
  input  logic [DATA_W-1:0] wrData,
  input  logic              flush,
  input  logic              pop,
  output logic [DATA_W-1:0] rdData,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level,
  output logic              overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wrPtr, rdPtr;
  logic [LVL_W-1:0]  lvlNext;
  logic              push, popOk;

  // full is the registered flag, so a pop in the same cycle does not open a slot
  assign push   = wrEn & ~full & ~flush;
  assign popOk  = pop & ~empty;
  assign rdData = mem[rdPtr];

  always_comb begin
    lvlNext = level;
    if (flush) lvlNext = '0;
    else       lvlNext = level + LVL_W'(push) - LVL_W'(popOk);
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wrPtr] <= wrData;
  end

  // Pointers are AW bits wide so they wrap modulo FIFO_DEPTH on their own
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      level    <= lvlNext;
      full     <= (lvlNext == LVL_W'(FIFO_DEPTH));
      empty    <= (lvlNext == '0);
      overflow <= wrEn & full & ~flush;
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (push)  wrPtr <= wrPtr + AW'(1);
        if (popOk) rdPtr <= rdPtr + AW'(1);
      end
    end
  end
endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmit path: write FIFO plus frame serialiser, one clock domain.
//  CLK/RESETn : clock, async active-low reset
//  bus        : FIFO push/flush strobes and FIFO status (uart_tx_fifo_ctrl_if.slave)
//  BAUD_TICK  : one pulse per 1/OVS bit period
//  TX_EN, DATA_BITS, PARITY, STOP2 : frame start enable and frame format
//  SEND_BREAK : hold TXD low while high (taken between frames)
//  CTS_n      : clear-to-send, only when UART_TX_CTS_EN is defined
//  TXD, TX_BUSY, TX_DONE : serial line, non-idle flag, end-of-frame pulse
// Optional feature macro: UART_TX_CTS_EN (CTS flow control on frame starts).
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVS        = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RESETn,
  uart_tx_fifo_ctrl_if.slave bus,
  input  logic               BAUD_TICK,
  input  logic               TX_EN,
  input  logic [3:0]         DATA_BITS,
  input  logic [1:0]         PARITY,
  input  logic               STOP2,
  input  logic               SEND_BREAK,
`ifdef UART_TX_CTS_EN
  input  logic               CTS_n,
`endif
  output logic               TXD,
  output logic               TX_BUSY,
  output logic               TX_DONE
);
  localparam int TW = $clog2(OVS);

  tx_state_t         state, nextState;
  logic [TW-1:0]     tick;
  logic              bitEnd, pop, ctsOk, canStart, txdNext, doneNext;
  logic [3:0]        bitCnt, cntNext, nBits, cfgBits;
  logic [1:0]        parMode;
  logic              stop2Lat, parBit;
  logic [DATA_W-1:0] rdData, rdMasked, shReg, shNext;

  uart_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .CLK(CLK), .RESETn(RESETn),
    .wrEn(bus.WR_EN), .wrData(bus.WR_DATA), .flush(bus.FIFO_FLUSH), .pop(pop),
    .rdData(rdData), .full(bus.FULL), .empty(bus.EMPTY), .level(bus.LEVEL),
    .overflow(bus.OVERFLOW)
  );

`ifdef UART_TX_CTS_EN
  logic [1:0] ctsSync;
  // Resets to "not clear" so nothing starts until CTS_n has been sampled
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) ctsSync <= 2'b11;
    else         ctsSync <= {ctsSync[0], CTS_n};
  end
  assign ctsOk = ~ctsSync[1];
`else
  assign ctsOk = 1'b1;
`endif

  assign cfgBits  = clampBits(DATA_BITS, DATA_W);
  assign canStart = TX_EN & ~bus.EMPTY & ctsOk;
  assign bitEnd   = BAUD_TICK & (tick == TW'(OVS - 1));
  assign TX_BUSY  = (state != IDLE);

  // Unused high bits are zeroed at load so parity only sees the frame bits
  always_comb begin
    rdMasked = '0;
    for (int i = 0; i < DATA_W; i++) rdMasked[i] = rdData[i] & (4'(i) < cfgBits);
  end

  // Bit timer: held at zero outside a frame; wraps on every bit boundary
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)                          tick <= '0;
    else if (state == IDLE || state == BREAK) tick <= '0;
    else if (bitEnd)                      tick <= '0;
    else if (BAUD_TICK)                   tick <= tick + TW'(1);
  end

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    doneNext  = 1'b0;
    cntNext   = bitCnt;
    shNext    = shReg;
    case (state)
      IDLE: begin
        if (SEND_BREAK) nextState = BREAK;
        else if (canStart) begin
          nextState = START;
          pop       = 1'b1;
        end
      end
      START: if (bitEnd) begin
        nextState = DATA;
        cntNext   = '0;
      end
      DATA: if (bitEnd) begin
        shNext = shReg >> 1;
        if (bitCnt == nBits - 4'd1) begin
          cntNext   = '0;
          nextState = (parMode == PAR_ODD || parMode == PAR_EVEN) ? PAR : STOP;
        end else begin
          cntNext = bitCnt + 4'd1;
        end
      end
      PAR: if (bitEnd) begin
        nextState = STOP;
        cntNext   = '0;
      end
      STOP: if (bitEnd) begin
        if (stop2Lat && bitCnt == 4'd0) begin
          cntNext = 4'd1;
        end else begin
          doneNext = 1'b1;
          if (SEND_BREAK) nextState = BREAK;
          else if (canStart) begin
            nextState = START;
            pop       = 1'b1;
          end else nextState = IDLE;
        end
      end
      BREAK: if (!SEND_BREAK) nextState = IDLE;
      default: nextState = IDLE;
    endcase

    // TXD is registered, so it is driven from the state being entered
    case (nextState)
      START:   txdNext = 1'b0;
      DATA:    txdNext = shNext[0];
      PAR:     txdNext = parBit;
      BREAK:   txdNext = 1'b0;
      default: txdNext = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      TXD      <= 1'b1;
      TX_DONE  <= 1'b0;
      bitCnt   <= '0;
      shReg    <= '0;
      nBits    <= 4'(MIN_DATA_BITS);
      parMode  <= PAR_NONE;
      stop2Lat <= 1'b0;
      parBit   <= 1'b0;
    end else begin
      state   <= nextState;
      TXD     <= txdNext;
      TX_DONE <= doneNext;
      bitCnt  <= cntNext;
      if (pop) begin
        // Frame format is frozen here; later config changes wait for the next frame
        shReg    <= rdMasked;
        nBits    <= cfgBits;
        parMode  <= PARITY;
        stop2Lat <= STOP2;
        parBit   <= (PARITY == PAR_ODD) ? ~^rdMasked : ^rdMasked;
      end else begin
        shReg <= shNext;
      end
    end
  end
endmodule
